// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared widths, memory size, NOP encoding and fetch FSM states.
package if_fetch_stage_pkg;
    localparam int WORD_LEN       = 16;
    localparam int MEM_CELL_SIZE  = 8;
    localparam int INSTR_MEM_SIZE = 256;
    localparam logic [WORD_LEN-1:0] NOP = '0;
    typedef enum logic {FETCH_RUN = 1'b0, FETCH_HALT = 1'b1} fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; flush and non-load cycles insert a zero bubble.
module ifid_reg
    import if_fetch_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                freeze,
    input  logic                load,
    input  logic [WORD_LEN-1:0] pc_i,
    input  logic [WORD_LEN-1:0] instr_i,
    output logic [WORD_LEN-1:0] pc_o,
    output logic [WORD_LEN-1:0] instr_o,
    output logic                valid_o
);
    logic [WORD_LEN-1:0] pc_q, instr_q;
    logic                valid_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (!freeze) begin
            pc_q    <= load ? pc_i : '0;
            instr_q <= load ? instr_i : NOP;
            valid_q <= load;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, next-PC mux, RUN/HALT FSM and fetch counter feeding the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned         PROG_END = INSTR_MEM_SIZE,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic [WORD_LEN-1:0] imem_instr,
    output logic [WORD_LEN-1:0] ifid_pc,
    output logic [WORD_LEN-1:0] ifid_instr,
    output logic                ifid_valid,
    output logic                halted,
    output logic [15:0]         fetch_count
);
    // One extra bit so PROG_END may equal 2^WORD_LEN.
    localparam logic [WORD_LEN:0] END_W = (WORD_LEN+1)'(PROG_END);

    logic [WORD_LEN-1:0] pc_q, pc_d, tgt, pc_inc;
    fetch_state_t        state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                halted_q, fetch, advance;

    assign tgt     = branch_target & ~WORD_LEN'(1);
    assign pc_inc  = pc_q + WORD_LEN'(2);
    assign fetch   = (state_q == FETCH_RUN) && ({1'b0, pc_q} < END_W);
    assign advance = !branch_taken && !freeze && fetch;

    always_comb begin
        pc_d    = branch_taken ? tgt : advance ? pc_inc : pc_q;
        state_d = branch_taken ? (({1'b0, tgt} < END_W) ? FETCH_RUN : state_q)
                : (freeze || fetch) ? state_q : FETCH_HALT;
        cnt_d   = (advance && !(&cnt_q)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            state_q  <= FETCH_RUN;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_q <= (state_d == FETCH_HALT);
            cnt_q    <= cnt_d;
        end
    end

    ifid_reg u_ifid (
        .clk     (clk),
        .rst     (rst),
        .flush   (branch_taken),
        .freeze  (freeze),
        .load    (fetch),
        .pc_i    (pc_inc),
        .instr_i (imem_instr),
        .pc_o    (ifid_pc),
        .instr_o (ifid_instr),
        .valid_o (ifid_valid)
    );

    assign imem_addr   = pc_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed test-plan scenarios plus random stimulus against a behavioural fetch model.
module tb_if_fetch_stage;
    localparam int PE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1, freeze = 1'b0, branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] imem_addr, imem_instr, ifid_pc, ifid_instr, fetch_count;
    logic        ifid_valid, halted;
    logic [15:0] mem [0:63];

    int errors = 0, checks = 0;

    logic [15:0] m_pc, m_ipc, m_ins, m_cnt;
    bit          m_v, m_halt;

    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input logic [15:0] a);
        return (a < 16'd128) ? mem[a[6:1]] : 16'hDEAD;
    endfunction

    assign imem_instr = rd(imem_addr);

    if_fetch_stage #(.PROG_END(PE), .RESET_PC(16'd0)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fetch behaviour expressed as one transaction per clock in plain terms.
    task automatic model(input bit r, input bit f, input bit b, input logic [15:0] t);
        int nt;
        nt = t - (t % 2);
        if (r) begin
            m_pc = 0; m_ipc = 0; m_ins = 0; m_v = 0; m_halt = 0; m_cnt = 0;
        end else if (b) begin
            m_pc = 16'(nt); m_ipc = 0; m_ins = 0; m_v = 0;
            if (nt < PE) m_halt = 0;
        end else if (!f) begin
            if (!m_halt && m_pc < PE) begin
                m_ins = rd(m_pc); m_ipc = 16'((m_pc + 2) % 65536); m_v = 1;
                m_pc = m_ipc;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end else begin
                m_ipc = 0; m_ins = 0; m_v = 0; m_halt = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit f, input bit b, input logic [15:0] t);
        rst = r; freeze = f; branch_taken = b; branch_target = t;
        @(posedge clk);
        model(r, f, b, t);
        @(negedge clk);
        check("imem_addr", imem_addr, m_pc);
        check("ifid_pc", ifid_pc, m_ipc);
        check("ifid_instr", ifid_instr, m_ins);
        check("ifid_valid", ifid_valid, m_v);
        check("halted", halted, m_halt);
        check("fetch_count", fetch_count, m_cnt);
    endtask

    initial begin
        mem[0] = 16'h0620; mem[1] = 16'h0620; mem[2] = 16'h3106; mem[3] = 16'h8800;
        for (int i = 4; i < 64; i++) mem[i] = 16'($urandom);
        @(negedge clk);
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        check("rst_pc", imem_addr, 16'd0);
        check("rst_valid", ifid_valid, 1'b0);
        step(0, 0, 0, 0);
        check("run1_instr", ifid_instr, 16'h0620); check("run1_pc", ifid_pc, 16'd2);
        step(0, 0, 0, 0);
        check("run2_pc", ifid_pc, 16'd4);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            check("frz_addr", imem_addr, 16'd4); check("frz_ifid_pc", ifid_pc, 16'd4);
        end
        step(0, 0, 0, 0);
        check("run3_instr", ifid_instr, 16'h3106); check("run3_pc", ifid_pc, 16'd6);
        step(0, 0, 0, 0);
        check("run4_instr", ifid_instr, 16'h8800); check("run4_pc", ifid_pc, 16'd8);
        check("run4_cnt", fetch_count, 16'd4); check("run4_halted", halted, 1'b0);
        step(0, 0, 0, 0);
        check("halt_flag", halted, 1'b1); check("halt_bubble", ifid_valid, 1'b0);
        step(0, 0, 1, 16'd0);
        check("recover_halted", halted, 1'b0); check("recover_addr", imem_addr, 16'd0);
        step(0, 0, 0, 0);
        check("recover_instr", ifid_instr, 16'h0620);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("pre_br_addr", imem_addr, 16'd6);
        step(0, 1, 1, 16'h0003);
        check("br_addr", imem_addr, 16'd2); check("br_valid", ifid_valid, 1'b0);
        check("br_instr", ifid_instr, 16'd0);
        step(0, 0, 0, 0);
        check("br_tgt_pc", ifid_pc, 16'd4); check("br_tgt_valid", ifid_valid, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("halt2", halted, 1'b1);
        step(0, 0, 1, 16'd10);
        check("far_addr", imem_addr, 16'd10); check("far_halted", halted, 1'b1);
        step(0, 0, 0, 0);
        check("far_hold", imem_addr, 16'd10);
        step(0, 0, 1, 16'd0); step(0, 0, 0, 0);
        step(1, 1, 1, 16'd4);
        check("mrst_pc", imem_addr, 16'd0); check("mrst_valid", ifid_valid, 1'b0);
        check("mrst_cnt", fetch_count, 16'd0); check("mrst_halted", halted, 1'b0);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] t;
            t = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 13));
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, t);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
